// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single write port of the register file between two writeback
// requesters: port A (ALU/EX writeback) and port B (load/MEM writeback).
// Each requester pushes into its own small FIFO through a valid/ready
// handshake. A round-robin arbiter drains one entry per cycle into registered
// outputs that drive the register file write port directly.
//
// Optional build macro: RF_ARB_PENDING_EN
//   When defined, adds two read-address probe ports (rA_address, rB_address)
//   and two flags (rA_pending, rB_pending). A flag is high while its probe
//   address matches a buffered write or the write currently on the port.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high
//   a_valid/a_ready, a_addr, a_data, a_ppp   requester A handshake and fields
//   b_valid/b_ready, b_addr, b_data, b_ppp   requester B handshake and fields
//   writeEnable    register file write strobe (registered)
//   rD_address     register file write address (registered)
//   rD_data        register file write data (registered)
//   ppp            register file partition select (registered)
//   busy           any FIFO non-empty or writeEnable high
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 64,
   parameter int PPP_W  = 3
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic [PPP_W-1:0]  a_ppp,

   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   input  logic [PPP_W-1:0]  b_ppp,

`ifdef RF_ARB_PENDING_EN
   input  logic [ADDR_W-1:0] rA_address,
   input  logic [ADDR_W-1:0] rB_address,
   output logic              rA_pending,
   output logic              rB_pending,
`endif

   output logic              writeEnable,
   output logic [ADDR_W-1:0] rD_address,
   output logic [DATA_W-1:0] rD_data,
   output logic [PPP_W-1:0]  ppp,
   output logic              busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Index 0 is port A, index 1 is port B throughout.
   logic [ADDR_W-1:0] addr_mem [2][DEPTH];
   logic [DATA_W-1:0] data_mem [2][DEPTH];
   logic [PPP_W-1:0]  ppp_mem  [2][DEPTH];
   logic [PTR_W-1:0]  wr_ptr   [2];
   logic [PTR_W-1:0]  rd_ptr   [2];
   logic [CNT_W-1:0]  count    [2];

   logic [ADDR_W-1:0] in_addr  [2];
   logic [DATA_W-1:0] in_data  [2];
   logic [PPP_W-1:0]  in_ppp   [2];
   logic [1:0]        in_valid;
   logic [1:0]        full;
   logic [1:0]        not_empty;
   logic [1:0]        push;
   logic [1:0]        grant;
   logic              gnt_sel;
   logic              last_grant_b;

   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [PPP_W-1:0]  head_ppp;

   assign in_valid   = {b_valid, a_valid};
   assign in_addr[0] = a_addr;
   assign in_addr[1] = b_addr;
   assign in_data[0] = a_data;
   assign in_data[1] = b_data;
   assign in_ppp[0]  = a_ppp;
   assign in_ppp[1]  = b_ppp;

   always_comb begin
      full      = '0;
      not_empty = '0;
      for (int p = 0; p < 2; p++) begin
         full[p]      = (count[p] == FULL_CNT);
         not_empty[p] = (count[p] != '0);
      end
   end

   // Ready depends on registered occupancy only; a full FIFO refuses a push
   // even when it is being popped in the same cycle.
   assign a_ready = ~full[0];
   assign b_ready = ~full[1];
   assign push    = in_valid & ~full;

   // Round-robin: on contention the port that did not win last time goes.
   always_comb begin
      grant = 2'b00;
      case (not_empty)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_b ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign gnt_sel   = grant[1];
   assign head_addr = addr_mem[gnt_sel][rd_ptr[gnt_sel]];
   assign head_data = data_mem[gnt_sel][rd_ptr[gnt_sel]];
   assign head_ppp  = ppp_mem[gnt_sel][rd_ptr[gnt_sel]];

   // Storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (push[p]) begin
            addr_mem[p][wr_ptr[p]] <= in_addr[p];
            data_mem[p][wr_ptr[p]] <= in_data[p];
            ppp_mem[p][wr_ptr[p]]  <= in_ppp[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            wr_ptr[p] <= '0;
            rd_ptr[p] <= '0;
            count[p]  <= '0;
         end
         last_grant_b <= 1'b1;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
               wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
            end
            if (grant[p]) begin
               rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
            end
            case ({push[p], grant[p]})
               2'b10:   count[p] <= count[p] + CNT_W'(1);
               2'b01:   count[p] <= count[p] - CNT_W'(1);
               default: count[p] <= count[p];
            endcase
         end
         if (grant != 2'b00) begin
            last_grant_b <= grant[1];
         end
      end
   end

   // Address/data/ppp hold their last value on idle cycles; only the strobe
   // drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         writeEnable <= 1'b0;
         rD_address  <= '0;
         rD_data     <= '0;
         ppp         <= '0;
      end else if (grant != 2'b00) begin
         writeEnable <= 1'b1;
         rD_address  <= head_addr;
         rD_data     <= head_data;
         ppp         <= head_ppp;
      end else begin
         writeEnable <= 1'b0;
      end
   end

   assign busy = (|not_empty) | writeEnable;

`ifdef RF_ARB_PENDING_EN
   logic [ADDR_W-1:0] probe_addr [2];
   logic [1:0]        probe_hit;

   assign probe_addr[0] = rA_address;
   assign probe_addr[1] = rB_address;

   // Only slots between the read pointer and read pointer + count hold live
   // entries; stale slots must not raise a hazard.
   always_comb begin
      probe_hit = '0;
      for (int q = 0; q < 2; q++) begin
         if (writeEnable && (rD_address == probe_addr[q])) begin
            probe_hit[q] = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
               if ((CNT_W'(i) < count[p]) &&
                   (addr_mem[p][rd_ptr[p] + PTR_W'(i)] == probe_addr[q])) begin
                  probe_hit[q] = 1'b1;
               end
            end
         end
      end
   end

   assign rA_pending = probe_hit[0];
   assign rB_pending = probe_hit[1];
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
   localparam int DEPTH  = 2;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 64;
   localparam int PPP_W  = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              a_valid = 1'b0;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr = '0;
   logic [DATA_W-1:0] a_data = '0;
   logic [PPP_W-1:0]  a_ppp = '0;
   logic              b_valid = 1'b0;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr = '0;
   logic [DATA_W-1:0] b_data = '0;
   logic [PPP_W-1:0]  b_ppp = '0;
   logic              writeEnable;
   logic [ADDR_W-1:0] rD_address;
   logic [DATA_W-1:0] rD_data;
   logic [PPP_W-1:0]  ppp;
   logic              busy;
`ifdef RF_ARB_PENDING_EN
   logic [ADDR_W-1:0] rA_address = '0;
   logic [ADDR_W-1:0] rB_address = '0;
   logic              rA_pending;
   logic              rB_pending;
`endif

   always #5 clk = ~clk;

   rf_write_arbiter #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PPP_W(PPP_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .a_valid(a_valid),
      .a_ready(a_ready),
      .a_addr(a_addr),
      .a_data(a_data),
      .a_ppp(a_ppp),
      .b_valid(b_valid),
      .b_ready(b_ready),
      .b_addr(b_addr),
      .b_data(b_data),
      .b_ppp(b_ppp),
`ifdef RF_ARB_PENDING_EN
      .rA_address(rA_address),
      .rB_address(rB_address),
      .rA_pending(rA_pending),
      .rB_pending(rB_pending),
`endif
      .writeEnable(writeEnable),
      .rD_address(rD_address),
      .rD_data(rD_data),
      .ppp(ppp),
      .busy(busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model: two queues and a turn flag ----------
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [PPP_W-1:0]  ppp;
   } ent_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [PPP_W-1:0]  ppp;
      int                cyc;
   } log_t;

   ent_t qa[$];
   ent_t qb[$];
   log_t wlog[$];

   bit                m_we = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_data = '0;
   logic [PPP_W-1:0]  m_ppp = '0;
   bit                m_b_went_last = 1'b1;
   bit                model_ok = 1'b0;
   int                cyc = 0;

   bit   acc_a, acc_b;
   int   winner;
   ent_t ent, nw;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            qa.delete();
            qb.delete();
            m_we = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_ppp = '0;
            m_b_went_last = 1'b1;
            model_ok = 1'b1;
         end else if (model_ok) begin
            acc_a = a_valid && (qa.size() < DEPTH);
            acc_b = b_valid && (qb.size() < DEPTH);
            winner = 0;
            if (qa.size() > 0 && qb.size() > 0) winner = m_b_went_last ? 1 : 2;
            else if (qa.size() > 0)             winner = 1;
            else if (qb.size() > 0)             winner = 2;
            if (winner == 1) begin
               ent = qa.pop_front();
               m_b_went_last = 1'b0;
            end else if (winner == 2) begin
               ent = qb.pop_front();
               m_b_went_last = 1'b1;
            end
            m_we = (winner != 0);
            if (winner != 0) begin
               m_addr = ent.addr;
               m_data = ent.data;
               m_ppp  = ent.ppp;
            end
            if (acc_a) begin
               nw.addr = a_addr; nw.data = a_data; nw.ppp = a_ppp;
               qa.push_back(nw);
            end
            if (acc_b) begin
               nw.addr = b_addr; nw.data = b_data; nw.ppp = b_ppp;
               qb.push_back(nw);
            end
         end
      end
   end

`ifdef RF_ARB_PENDING_EN
   function automatic bit model_pending(input logic [ADDR_W-1:0] r);
      bit hit = m_we && (m_addr == r);
      foreach (qa[i]) if (qa[i].addr == r) hit = 1'b1;
      foreach (qb[i]) if (qb[i].addr == r) hit = 1'b1;
      return hit;
   endfunction
`endif

   // ---------------- per-cycle comparison against the model ----------------
   log_t lg;
   always @(negedge clk) begin
      if (model_ok) begin
         check("writeEnable", writeEnable, m_we);
         check("rD_address", rD_address, m_addr);
         check("rD_data", rD_data, m_data);
         check("ppp", ppp, m_ppp);
         check("a_ready", a_ready, qa.size() != DEPTH);
         check("b_ready", b_ready, qb.size() != DEPTH);
         check("busy", busy, (qa.size() != 0) || (qb.size() != 0) || m_we);
`ifdef RF_ARB_PENDING_EN
         check("rA_pending", rA_pending, model_pending(rA_address));
         check("rB_pending", rB_pending, model_pending(rB_address));
`endif
         if (writeEnable === 1'b1) begin
            lg.addr = rD_address; lg.data = rD_data; lg.ppp = ppp; lg.cyc = cyc;
            wlog.push_back(lg);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      repeat (2) cycle();
      reset = 1'b0;
   endtask

   task automatic send_a(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d,
                         input logic [PPP_W-1:0] p);
      bit r;
      bit done = 1'b0;
      a_valid = 1'b1; a_addr = ad; a_data = d; a_ppp = p;
      for (int k = 0; k < 30 && !done; k++) begin
         @(negedge clk);
         r = a_ready;
         cycle();
         if (r) done = 1'b1;
      end
      check("a_accept", done, 1'b1);
      a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d,
                         input logic [PPP_W-1:0] p);
      bit r;
      bit done = 1'b0;
      b_valid = 1'b1; b_addr = ad; b_data = d; b_ppp = p;
      for (int k = 0; k < 30 && !done; k++) begin
         @(negedge clk);
         r = b_ready;
         cycle();
         if (r) done = 1'b1;
      end
      check("b_accept", done, 1'b1);
      b_valid = 1'b0;
   endtask

   int ord2 [6] = '{2, 10, 3, 11, 4, 12};
   int ord3 [7] = '{20, 24, 21, 25, 22, 26, 23};
   int n_before;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values ----
      do_reset();
      check("rst_we", writeEnable, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_a_ready", a_ready, 1'b1);
      check("rst_b_ready", b_ready, 1'b1);
      check("rst_addr", rD_address, 5'd0);
      check("rst_data", rD_data, 64'd0);

      // ---- single write latency ----
      a_valid = 1'b1; a_addr = 5'd1; a_data = 64'h200200000000FA50; a_ppp = 3'b000;
      cycle();
      a_valid = 1'b0;
      check("t1_we_after_accept", writeEnable, 1'b0);
      check("t1_busy_queued", busy, 1'b1);
      cycle();
      check("t1_we", writeEnable, 1'b1);
      check("t1_addr", rD_address, 5'd1);
      check("t1_data", rD_data, 64'h200200000000FA50);
      cycle();
      check("t1_we_drop", writeEnable, 1'b0);
      check("t1_busy_idle", busy, 1'b0);

      // ---- contention: strict alternation, A first after reset ----
      do_reset();
      wlog.delete();
      fork
         begin
            for (int i = 2; i <= 4; i++) send_a(ADDR_W'(i), 64'hA000 + 64'(i), PPP_W'(i));
         end
         begin
            for (int i = 10; i <= 12; i++) send_b(ADDR_W'(i), 64'hB000 + 64'(i), PPP_W'(i));
         end
      join
      repeat (8) cycle();
      check("t2_count", wlog.size(), 6);
      if (wlog.size() == 6) begin
         for (int i = 0; i < 6; i++) check("t2_order", wlog[i].addr, ord2[i]);
         for (int i = 1; i < 6; i++) check("t2_back_to_back", wlog[i].cyc - wlog[i-1].cyc, 1);
      end

      // ---- B fills under contention, third entry waits for a pop ----
      do_reset();
      wlog.delete();
      fork
         begin
            for (int i = 20; i <= 23; i++) send_a(ADDR_W'(i), 64'hC000 + 64'(i), PPP_W'(i));
         end
         begin
            for (int i = 24; i <= 26; i++) send_b(ADDR_W'(i), 64'hD000 + 64'(i), PPP_W'(i));
         end
         begin
            cycle();
            check("t3_b_ready_one", b_ready, 1'b1);
            cycle();
            check("t3_b_ready_full", b_ready, 1'b0);
            cycle();
            check("t3_b_ready_popped", b_ready, 1'b1);
         end
      join
      repeat (10) cycle();
      check("t3_count", wlog.size(), 7);
      if (wlog.size() == 7) begin
         for (int i = 0; i < 7; i++) check("t3_order", wlog[i].addr, ord3[i]);
         check("t3_b26_data", wlog[5].data, 64'hD000 + 64'd26);
      end

      // ---- ppp pass-through ----
      wlog.delete();
      send_b(5'd5, 64'h00020000000ABCDE, 3'b101);
      repeat (4) cycle();
      check("t4_count", wlog.size(), 1);
      if (wlog.size() == 1) begin
         check("t4_addr", wlog[0].addr, 5'd5);
         check("t4_data", wlog[0].data, 64'h00020000000ABCDE);
         check("t4_ppp", wlog[0].ppp, 3'b101);
      end

      // ---- reset mid-operation ----
      do_reset();
      wlog.delete();
      a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h77; a_ppp = 3'd1;
      b_valid = 1'b1; b_addr = 5'd8; b_data = 64'h88; b_ppp = 3'd2;
      repeat (3) cycle();
      check("t5_we_before", writeEnable, 1'b1);
      check("t5_a_full_before", a_ready, 1'b0);
      reset = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      cycle();
      check("t5_we_cleared", writeEnable, 1'b0);
      check("t5_a_ready", a_ready, 1'b1);
      check("t5_b_ready", b_ready, 1'b1);
      check("t5_busy", busy, 1'b0);
      n_before = wlog.size();
      reset = 1'b0;
      repeat (5) cycle();
      check("t5_no_more_writes", wlog.size(), n_before);
      check("t5_busy_after", busy, 1'b0);

`ifdef RF_ARB_PENDING_EN
      // ---- pending flags ----
      do_reset();
      rA_address = 5'd10;
      rB_address = 5'd4;
      a_valid = 1'b1; a_addr = 5'd10; a_data = 64'h1010; a_ppp = 3'd0;
      cycle();
      a_valid = 1'b0;
      check("t6_rA_queued", rA_pending, 1'b1);
      check("t6_rB_clear", rB_pending, 1'b0);
      cycle();
      check("t6_rA_on_port", rA_pending, 1'b1);
      cycle();
      check("t6_rA_committed", rA_pending, 1'b0);
`endif

      repeat (2) cycle();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
